// File: rtl/sdram_port_arbiter.sv
// Three-client arbiter in front of a single SDRAM channel: one outstanding
// transaction at a time, round-robin or fixed priority, with a wait-cycle timeout.
module sdram_port_arbiter #(
    parameter bit         RR      = 1'b1,
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [25:0] c0_addr,
    input  logic [15:0] c0_din,
    input  logic [1:0]  c0_be,
    input  logic        c0_rnw,
    input  logic        c0_req,
    output logic        c0_ack,
    output logic [15:0] c0_dout,
    output logic        c0_err,

    input  logic [25:0] c1_addr,
    input  logic [15:0] c1_din,
    input  logic [1:0]  c1_be,
    input  logic        c1_rnw,
    input  logic        c1_req,
    output logic        c1_ack,
    output logic [15:0] c1_dout,
    output logic        c1_err,

    input  logic [25:0] c2_addr,
    input  logic [15:0] c2_din,
    input  logic [1:0]  c2_be,
    input  logic        c2_rnw,
    input  logic        c2_req,
    output logic        c2_ack,
    output logic [15:0] c2_dout,
    output logic        c2_err,

    output logic [25:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_be,
    output logic        mem_rnw,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [15:0] mem_dout,

    output logic        busy,
    output logic        timeout_flag,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [25:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        mem_rnw_q, mem_rnw_d;
    logic        mem_req_q, mem_req_d;
    logic [2:0]  ack_q, ack_d;
    logic [2:0]  err_q, err_d;
    logic [15:0] dout_q [3];
    logic [15:0] dout_d [3];
    logic        busy_q, busy_d;
    logic        tflag_q, tflag_d;

    logic [25:0] c_addr [3];
    logic [15:0] c_din  [3];
    logic [1:0]  c_be   [3];
    logic [2:0]  c_rnw;
    logic [2:0]  c_req;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [2:0]  cand;

    assign c_addr[0] = c0_addr;
    assign c_addr[1] = c1_addr;
    assign c_addr[2] = c2_addr;
    assign c_din[0]  = c0_din;
    assign c_din[1]  = c1_din;
    assign c_din[2]  = c2_din;
    assign c_be[0]   = c0_be;
    assign c_be[1]   = c1_be;
    assign c_be[2]   = c2_be;
    assign c_rnw     = {c2_rnw, c1_rnw, c0_rnw};
    assign c_req     = {c2_req, c1_req, c0_req};

    // rr_ptr_q holds the client the search starts from (one past the last served).
    // Candidates are visited farthest-first so the nearest requester wins last.
    always_comb begin
        win_valid = |c_req;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            if (RR) begin
                cand = {1'b0, rr_ptr_q} + 3'(k);
                if (cand >= 3'd3) begin
                    cand = cand - 3'd3;
                end
            end else begin
                cand = 3'(k);
            end
            if (c_req[cand[1:0]]) begin
                win_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        mem_rnw_d  = mem_rnw_q;
        mem_req_d  = 1'b0;
        ack_d      = 3'b000;
        err_d      = 3'b000;
        tflag_d    = tflag_q;
        for (int k = 0; k < 3; k++) begin
            dout_d[k] = dout_q[k];
        end

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    mem_addr_d = c_addr[win_idx];
                    mem_din_d  = c_din[win_idx];
                    mem_be_d   = c_be[win_idx];
                    mem_rnw_d  = c_rnw[win_idx];
                    mem_req_d  = 1'b1;
                    grant_d    = win_idx;
                    state_d    = ISSUE;
                end else begin
                    grant_d = GRANT_NONE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    for (int k = 0; k < 3; k++) begin
                        if (grant_q == 2'(k)) begin
                            ack_d[k] = 1'b1;
                            if (mem_rnw_q) begin
                                dout_d[k] = mem_dout;
                            end
                        end
                    end
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT) begin
                    for (int k = 0; k < 3; k++) begin
                        if (grant_q == 2'(k)) begin
                            ack_d[k] = 1'b1;
                            err_d[k] = 1'b1;
                            if (mem_rnw_q) begin
                                dout_d[k] = 16'hFFFF;
                            end
                        end
                    end
                    tflag_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
                grant_d  = GRANT_NONE;
                state_d  = IDLE;
            end
            default: begin
                grant_d = GRANT_NONE;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_NONE;
            rr_ptr_q   <= 2'd0;
            cnt_q      <= 8'd0;
            mem_addr_q <= 26'd0;
            mem_din_q  <= 16'd0;
            mem_be_q   <= 2'd0;
            mem_rnw_q  <= 1'b1;
            mem_req_q  <= 1'b0;
            ack_q      <= 3'b000;
            err_q      <= 3'b000;
            busy_q     <= 1'b0;
            tflag_q    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                dout_q[k] <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            mem_rnw_q  <= mem_rnw_d;
            mem_req_q  <= mem_req_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tflag_q    <= tflag_d;
            for (int k = 0; k < 3; k++) begin
                dout_q[k] <= dout_d[k];
            end
        end
    end

    assign c0_ack       = ack_q[0];
    assign c1_ack       = ack_q[1];
    assign c2_ack       = ack_q[2];
    assign c0_err       = err_q[0];
    assign c1_err       = err_q[1];
    assign c2_err       = err_q[2];
    assign c0_dout      = dout_q[0];
    assign c1_dout      = dout_q[1];
    assign c2_dout      = dout_q[2];
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_be       = mem_be_q;
    assign mem_rnw      = mem_rnw_q;
    assign mem_req      = mem_req_q;
    assign busy         = busy_q;
    assign timeout_flag = tflag_q;
    assign grant        = grant_q;

endmodule
